// File: rtl/mon_exp_ctrl.sv
// Left-to-right Montgomery exponentiation controller (ans = M_bar^e, Montgomery form).
// Sequences squarings/multiplies on an external product unit over an mp_start/mp_stop handshake.
module mon_exp_ctrl #(
  parameter int BITLEN   = 1024,
  parameter int EXP_BITS = 1024,
  parameter int LOG_EXP  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BITLEN-1:0]    M_bar,
  input  logic [BITLEN-1:0]    x_bar,
  input  logic [EXP_BITS-1:0]  e,
  input  logic [BITLEN-1:0]    n,
  output logic                 busy,
  output logic                 done,
  output logic [BITLEN-1:0]    ans,
  output logic [LOG_EXP+1:0]   op_count,
  output logic                 mp_start,
  output logic [BITLEN-1:0]    mp_A,
  output logic [BITLEN-1:0]    mp_B,
  output logic [BITLEN-1:0]    mp_M,
  input  logic                 mp_stop,
  input  logic [BITLEN-1:0]    mp_P
);

  localparam int OPW = LOG_EXP + 2;
  localparam logic [LOG_EXP-1:0] IDX_TOP  = LOG_EXP'(EXP_BITS - 1);
  localparam logic [LOG_EXP-1:0] IDX_ZERO = {LOG_EXP{1'b0}};
  localparam logic [LOG_EXP-1:0] IDX_ONE  = {{(LOG_EXP-1){1'b0}}, 1'b1};
  localparam logic [OPW-1:0]     OP_ZERO  = {OPW{1'b0}};
  localparam logic [OPW-1:0]     OP_ONE   = {{(OPW-1){1'b0}}, 1'b1};
  localparam logic [BITLEN-1:0]  W_ZERO   = {BITLEN{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_SQR_REQ  = 3'd2,
    S_SQR_WAIT = 3'd3,
    S_MUL_REQ  = 3'd4,
    S_MUL_WAIT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t               state_r, state_s;
  logic [BITLEN-1:0]    m_bar_r, m_bar_s;
  logic [BITLEN-1:0]    x_bar_r, x_bar_s;
  logic [EXP_BITS-1:0]  e_r, e_s;
  logic [BITLEN-1:0]    acc_r, acc_s;
  logic [LOG_EXP-1:0]   idx_r, idx_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic [BITLEN-1:0]    ans_r, ans_s;
  logic [OPW-1:0]       op_count_r, op_count_s;
  logic                 mp_start_r, mp_start_s;
  logic [BITLEN-1:0]    mp_a_r, mp_a_s;
  logic [BITLEN-1:0]    mp_b_r, mp_b_s;
  logic [BITLEN-1:0]    mp_m_r, mp_m_s;
  logic                 last_s;
  logic                 bit_s;
  logic                 finish_s;

  assign last_s = (idx_r == IDX_ZERO);
  assign bit_s  = e_r[idx_r];

  // Next-state and datapath decode; every path tests idx==0 before decrementing.
  always_comb begin
    state_s    = state_r;
    m_bar_s    = m_bar_r;
    x_bar_s    = x_bar_r;
    e_s        = e_r;
    acc_s      = acc_r;
    idx_s      = idx_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    ans_s      = ans_r;
    op_count_s = op_count_r;
    mp_start_s = 1'b0;
    mp_a_s     = mp_a_r;
    mp_b_s     = mp_b_r;
    mp_m_s     = mp_m_r;
    finish_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          m_bar_s    = M_bar;
          x_bar_s    = x_bar;
          e_s        = e;
          mp_m_s     = n;
          idx_s      = IDX_TOP;
          op_count_s = OP_ZERO;
          busy_s     = 1'b1;
          state_s    = S_SCAN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SCAN: begin
        // A clear bit loads the Montgomery one so e==0 ends with acc = R mod n.
        acc_s = bit_s ? m_bar_r : x_bar_r;
        if (last_s) begin
          finish_s = 1'b1;
        end else begin
          idx_s   = idx_r - IDX_ONE;
          state_s = bit_s ? S_SQR_REQ : S_SCAN;
        end
      end
      S_SQR_REQ: begin
        mp_start_s = 1'b1;
        mp_a_s     = acc_r;
        mp_b_s     = acc_r;
        op_count_s = op_count_r + OP_ONE;
        state_s    = S_SQR_WAIT;
      end
      S_SQR_WAIT: begin
        if (mp_stop) begin
          acc_s = mp_P;
          if (bit_s) begin
            state_s = S_MUL_REQ;
          end else if (last_s) begin
            finish_s = 1'b1;
          end else begin
            idx_s   = idx_r - IDX_ONE;
            state_s = S_SQR_REQ;
          end
        end else begin
          state_s = S_SQR_WAIT;
        end
      end
      S_MUL_REQ: begin
        mp_start_s = 1'b1;
        mp_a_s     = m_bar_r;
        mp_b_s     = acc_r;
        op_count_s = op_count_r + OP_ONE;
        state_s    = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mp_stop) begin
          acc_s = mp_P;
          if (last_s) begin
            finish_s = 1'b1;
          end else begin
            idx_s   = idx_r - IDX_ONE;
            state_s = S_SQR_REQ;
          end
        end else begin
          state_s = S_MUL_WAIT;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    if (finish_s) begin
      ans_s   = acc_s;
      done_s  = 1'b1;
      busy_s  = 1'b0;
      state_s = S_DONE;
    end else begin
      ans_s = ans_r;
    end
  end

  // State and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      m_bar_r    <= W_ZERO;
      x_bar_r    <= W_ZERO;
      e_r        <= {EXP_BITS{1'b0}};
      acc_r      <= W_ZERO;
      idx_r      <= IDX_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ans_r      <= W_ZERO;
      op_count_r <= OP_ZERO;
      mp_start_r <= 1'b0;
      mp_a_r     <= W_ZERO;
      mp_b_r     <= W_ZERO;
      mp_m_r     <= W_ZERO;
    end else begin
      state_r    <= state_s;
      m_bar_r    <= m_bar_s;
      x_bar_r    <= x_bar_s;
      e_r        <= e_s;
      acc_r      <= acc_s;
      idx_r      <= idx_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      ans_r      <= ans_s;
      op_count_r <= op_count_s;
      mp_start_r <= mp_start_s;
      mp_a_r     <= mp_a_s;
      mp_b_r     <= mp_b_s;
      mp_m_r     <= mp_m_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign ans      = ans_r;
  assign op_count = op_count_r;
  assign mp_start = mp_start_r;
  assign mp_A     = mp_a_r;
  assign mp_B     = mp_b_r;
  assign mp_M     = mp_m_r;

endmodule

// File: tb/tb_mon_exp_ctrl.sv
// Scoreboard bench for mon_exp_ctrl with a behavioural Montgomery product unit (n=13, R=256).
module tb_mon_exp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] M_bar, x_bar, e, n;
  logic       busy, done;
  logic [7:0] ans;
  logic [4:0] op_count;
  logic       mp_start;
  logic [7:0] mp_A, mp_B, mp_M;
  logic       mp_stop;
  logic [7:0] mp_P;

  logic       mp_stop_m = 1'b0;
  logic       spur_stop = 1'b0;
  logic [7:0] mp_p_m = 8'd0;
  int         stall = 0;
  int         cyc = 0;
  int         prod_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    int ans;
    int opc;
    int t0;
    int lat;
    int pbase;
  } exp_t;
  exp_t sb_q[$];

  assign mp_stop = mp_stop_m | spur_stop;
  assign mp_P    = mp_p_m;

  mon_exp_ctrl #(.BITLEN(8), .EXP_BITS(8), .LOG_EXP(3)) dut (
    .clk(clk), .rst(rst), .start(start), .M_bar(M_bar), .x_bar(x_bar), .e(e), .n(n),
    .busy(busy), .done(done), .ans(ans), .op_count(op_count),
    .mp_start(mp_start), .mp_A(mp_A), .mp_B(mp_B), .mp_M(mp_M),
    .mp_stop(mp_stop), .mp_P(mp_P)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // A*B*R^-1 mod 13, with R^-1 found by search
  function automatic int mont(input int a, input int b);
    int ri = 0;
    for (int r = 1; r < 13; r++) if ((256 * r) % 13 == 1) ri = r;
    return (a * b * ri) % 13;
  endfunction

  // Montgomery form of 2^ev mod 13
  function automatic int exp_ans(input int ev);
    int p = 1;
    for (int i = 0; i < ev; i++) p = (p * 2) % 13;
    return (p * 9) % 13;
  endfunction

  function automatic int exp_ops(input int ev);
    int k = -1;
    int pc = 0;
    for (int i = 0; i < 8; i++) if (((ev >> i) & 1) == 1) begin k = i; pc++; end
    return (ev == 0) ? 0 : (k + pc - 1);
  endfunction

  // Behavioural product unit, evaluated on the falling edge
  int   mp_cnt = 0;
  bit   mp_pend = 1'b0;
  int   cap_a, cap_b, mp_res;
  always @(negedge clk) begin
    mp_stop_m = 1'b0;
    if (mp_pend) begin
      if (mp_cnt == 0) begin
        if (busy) begin
          chk("mp_A_stable", int'(mp_A), cap_a);
          chk("mp_B_stable", int'(mp_B), cap_b);
        end
        mp_p_m    = 8'(mp_res);
        mp_stop_m = 1'b1;
        mp_pend   = 1'b0;
      end else begin
        mp_cnt--;
      end
    end
    if (mp_start) begin
      prod_cnt++;
      chk("mp_M", int'(mp_M), 13);
      cap_a   = int'(mp_A);
      cap_b   = int'(mp_B);
      mp_res  = mont(cap_a, cap_b);
      mp_cnt  = 2 + stall;
      mp_pend = 1'b1;
    end
  end

  // Scoreboard: pop and compare on every done pulse
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", sb_q.size(), 1);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        chk("ans", int'(ans), x.ans);
        chk("op_count", int'(op_count), x.opc);
        chk("products_issued", prod_cnt - x.pbase, x.opc);
        chk("busy_at_done", int'(busy), 0);
        if (x.lat >= 0) chk("latency", cyc - x.t0, x.lat);
      end
    end
  end

  task automatic run_start(input int ev, input int lat);
    exp_t x;
    @(negedge clk);
    e = 8'(ev);
    start = 1'b1;
    x.ans = exp_ans(ev);
    x.opc = exp_ops(ev);
    x.t0 = cyc + 1;
    x.lat = lat;
    x.pbase = prod_cnt;
    sb_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while ((sb_q.size() != 0 || busy) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (k >= maxc) begin
      chk("timeout_queue", sb_q.size(), 0);
      chk("timeout_busy", int'(busy), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    rst = 1'b1; start = 1'b0; e = 8'd0; M_bar = 8'd5; x_bar = 8'd9; n = 8'd13;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ans", int'(ans), 0);
    chk("rst_op_count", int'(op_count), 0);
    chk("rst_mp_start", int'(mp_start), 0);
    chk("rst_mp_A", int'(mp_A), 0);
    chk("rst_mp_B", int'(mp_B), 0);
    chk("rst_mp_M", int'(mp_M), 0);
    rst = 1'b0;

    run_start(0, 8);   wait_idle(200);
    run_start(1, -1);  wait_idle(200);
    run_start(5, -1);  wait_idle(200);
    run_start(255, -1); wait_idle(400);
    chk("ans_held", int'(ans), exp_ans(255));

    // start pulsed mid-run must be ignored
    run_start(5, -1);
    repeat (6) @(negedge clk);
    start = 1'b1; e = 8'd255;
    @(negedge clk);
    start = 1'b0; e = 8'd5;
    wait_idle(200);
    repeat (5) @(negedge clk);

    // reset while the multiply is outstanding
    run_start(5, -1);
    base = sb_q[0].pbase;
    k = 0;
    while (prod_cnt < base + 3 && k < 200) begin
      @(negedge clk); #1; k++;
    end
    chk("reached_mul", prod_cnt - base, 3);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ans", int'(ans), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("late_stop_busy", int'(busy), 0);
    chk("late_stop_ans", int'(ans), 0);
    run_start(5, -1); wait_idle(200);

    // spurious mp_stop in IDLE and SCAN, plus long product stall
    spur_stop = 1'b1;
    @(negedge clk);
    spur_stop = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", int'(busy), 0);
    chk("spur_idle_ans", int'(ans), exp_ans(5));
    stall = 50;
    run_start(5, -1);
    spur_stop = 1'b1;
    @(negedge clk);
    spur_stop = 1'b0;
    repeat (30) @(negedge clk);
    chk("stall_busy", int'(busy), 1);
    wait_idle(1000);
    stall = 0;

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
